sha2_core: RTL

- Iterative SHA-2 compression engine, one round per clock, parametrised for SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).
- Successor to the per-function SHA-512 helpers (S0/S1/s0/s1, K ROM, IV constants). Adds on-the-fly message schedule, multi-block chaining and a valid/ready block input.
- Sits between the padding/block formatter and the digest consumer.

---
 rtl/sha2_core.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sha2_core.sv
// Iterative SHA-256 / SHA-512 compression engine: one round per clock, on-the-fly schedule, block chaining.
// Optional macro SHA2_ALT_IV_EN adds iv_sel to load the SHA-224 / SHA-384 initial hash values.
module sha2_core #(
   parameter int    WORD_W = 64,
   parameter string K_FILE = "sha512_K.rom"
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  block_valid,
   output logic                  block_ready,
   input  logic                  init,
`ifdef SHA2_ALT_IV_EN
   input  logic                  iv_sel,
`endif
   input  logic [16*WORD_W-1:0]  block,
   output logic [8*WORD_W-1:0]   digest,
   output logic                  digest_valid
);

   localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_core: WORD_W must be 32 or 64");
   end
   // The K table is built in (SHA-256 K is the upper half of SHA-512 K); K_FILE only has to name something.
   if (K_FILE == "") begin : g_bad_kfile
      $error("sha2_core: K_FILE must not be empty");
   end

   localparam int BS0_A = (WORD_W == 64) ? 28 : 2;
   localparam int BS0_B = (WORD_W == 64) ? 34 : 13;
   localparam int BS0_C = (WORD_W == 64) ? 39 : 22;
   localparam int BS1_A = (WORD_W == 64) ? 14 : 6;
   localparam int BS1_B = (WORD_W == 64) ? 18 : 11;
   localparam int BS1_C = (WORD_W == 64) ? 41 : 25;
   localparam int SS0_A = (WORD_W == 64) ? 1  : 7;
   localparam int SS0_B = (WORD_W == 64) ? 8  : 18;
   localparam int SS0_S = (WORD_W == 64) ? 7  : 3;
   localparam int SS1_A = (WORD_W == 64) ? 19 : 17;
   localparam int SS1_B = (WORD_W == 64) ? 61 : 19;
   localparam int SS1_S = (WORD_W == 64) ? 6  : 10;

   localparam logic [63:0] K_TAB [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // SHA-256 IV is the upper half of the SHA-512 IV; SHA-224 IV is the lower half of the SHA-384 IV.
   localparam logic [63:0] IV_STD [8] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };
`ifdef SHA2_ALT_IV_EN
   localparam logic [63:0] IV_ALT [8] = '{
      64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
   };
`endif

   typedef enum logic [1:0] {IDLE, PREFETCH, ROUND, FINAL} state_t;

   state_t            state_q, state_d;
   logic [6:0]        round_q;
   logic              digest_valid_q;
   logic [WORD_W-1:0] h_q [8];
   logic [WORD_W-1:0] v_q [8];
   logic [WORD_W-1:0] w_q [16];
   logic [WORD_W-1:0] blk_w [16];
   logic [WORD_W-1:0] h_start [8];
   logic [WORD_W-1:0] k_q;
   logic [63:0]       k_rd;
   logic [6:0]        k_addr;
   logic [WORD_W-1:0] t1, t2, w_new;
   logic              accept;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      rotr = (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] big_s0(input logic [WORD_W-1:0] x);
      big_s0 = rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
   endfunction

   function automatic logic [WORD_W-1:0] big_s1(input logic [WORD_W-1:0] x);
      big_s1 = rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
   endfunction

   function automatic logic [WORD_W-1:0] small_s0(input logic [WORD_W-1:0] x);
      small_s0 = rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
   endfunction

   function automatic logic [WORD_W-1:0] small_s1(input logic [WORD_W-1:0] x);
      small_s1 = rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
   endfunction

   assign accept       = block_valid && (state_q == IDLE);
   assign block_ready  = (state_q == IDLE);
   assign digest_valid = digest_valid_q;

   genvar gi;
   for (gi = 0; gi < 16; gi++) begin : g_blk
      assign blk_w[gi] = block[(15-gi)*WORD_W +: WORD_W];
   end

   for (gi = 0; gi < 8; gi++) begin : g_chain
      localparam logic [63:0] STD = IV_STD[gi];
`ifdef SHA2_ALT_IV_EN
      localparam logic [63:0] ALT = IV_ALT[gi];
      assign h_start[gi] = init ? (iv_sel ? ALT[WORD_W-1:0] : STD[63 -: WORD_W]) : h_q[gi];
`else
      assign h_start[gi] = init ? STD[63 -: WORD_W] : h_q[gi];
`endif
      assign digest[(7-gi)*WORD_W +: WORD_W] = h_q[gi];
   end

   assign t1 = v_q[7] + big_s1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_q + w_q[0];
   assign t2 = big_s0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
   assign w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];

   // K ROM, one cycle ahead of the round that consumes it; addresses past the table read zero.
   assign k_addr = (state_q == ROUND) ? round_q + 7'd1 : 7'd0;
   assign k_rd   = (k_addr < 7'd80) ? K_TAB[k_addr] : 64'd0;

   always_ff @(posedge clk) begin
      k_q <= k_rd[63 -: WORD_W];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = PREFETCH;
         PREFETCH: state_d = ROUND;
         ROUND:    if (round_q == 7'(ROUNDS-1)) state_d = FINAL;
         FINAL:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         round_q        <= '0;
         digest_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            h_q[i] <= '0;
            v_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  digest_valid_q <= 1'b0;
                  for (int i = 0; i < 8; i++) begin
                     h_q[i] <= h_start[i];
                     v_q[i] <= h_start[i];
                  end
               end
            end
            PREFETCH: round_q <= '0;
            ROUND: begin
               round_q <= round_q + 7'd1;
               v_q[0]  <= t1 + t2;
               v_q[1]  <= v_q[0];
               v_q[2]  <= v_q[1];
               v_q[3]  <= v_q[2];
               v_q[4]  <= v_q[3] + t1;
               v_q[5]  <= v_q[4];
               v_q[6]  <= v_q[5];
               v_q[7]  <= v_q[6];
            end
            FINAL: begin
               digest_valid_q <= 1'b1;
               for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
            end
            default: ;
         endcase
      end
   end

   // w_q[0] always holds W[t] for the current round.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 16; i++) w_q[i] <= blk_w[i];
      end else if (state_q == ROUND) begin
         for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
         w_q[15] <= w_new;
      end
   end

endmodule
